matrix_accumulate_sequencer: RTL and testbench
==============================================

MATRIX_ACCUMULATE_SEQUENCER -- requirements
Module: matrix_accumulate_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 64, width of the accumulator datapath and captured result; PASS_WIDTH, default 4, width of the pass-count field.
REQ-002 Ports SHALL be as follows:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command; accepted only in IDLE.
- num_passes  in  PASS_WIDTH  number of partial results to sum; sampled on accepted start.
- abort  in  1  cancels an operation in progress.
- in_valid  in  1  a partial result is present on the datapath input.
- in_ready  out  1  the sequencer accepts a partial result this cycle.
- acc_out  in  DATA_WIDTH  accumulator unit "out" value.
- acc_clear  out  1  drives the accumulator "clear" input.
- acc_enable  out  1  drives the accumulator "enable" input.
- res_data  out  DATA_WIDTH  captured final sum.
- res_valid  out  1  res_data is valid.
- res_ready  in  1  downstream consumer takes res_data.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-003 The FSM states SHALL be IDLE, CLEAR, ACCUM and HOLD.
REQ-004 IDLE: on start=1 with num_passes!=0, the block SHALL latch num_passes into the remaining counter and go to CLEAR.
REQ-005 In IDLE, start=1 with num_passes==0 SHALL leave the state in IDLE and pulse err for exactly one cycle.
REQ-006 start SHALL be ignored in every state other than IDLE, with no err pulse.
REQ-007 CLEAR SHALL last exactly one cycle with acc_clear=1 and in_ready=0, then go to ACCUM.
REQ-008 ACCUM SHALL drive in_ready=1.
REQ-009 acc_enable SHALL equal (in_valid & in_ready), combinationally.
REQ-010 In ACCUM, each handshake cycle SHALL decrement the remaining counter by 1.
REQ-011 On the handshake with remaining==1, the block SHALL capture acc_out into res_data on the same edge and go to HOLD.
REQ-012 There SHALL be zero added latency from the last handshake to res_valid: res_valid=1 in the first HOLD cycle.
REQ-013 In ACCUM, cycles with in_valid=0 SHALL change no state and keep acc_enable=0.
REQ-014 HOLD SHALL keep res_valid=1 and res_data stable until res_ready=1.
REQ-015 On res_ready=1 in HOLD, the block SHALL go to IDLE and res_valid SHALL fall on the next cycle.
REQ-016 in_ready SHALL be 0 in HOLD.
REQ-017 abort=1 in CLEAR or ACCUM SHALL force the next state to IDLE and assert acc_clear for that one cycle.
REQ-018 On abort, res_valid SHALL stay 0 and the remaining counter SHALL be zeroed.
REQ-019 abort SHALL have priority over a simultaneous handshake in ACCUM; that beat is not counted and no result is captured.
REQ-020 abort in IDLE or HOLD SHALL be ignored; a result in HOLD is never discarded.
REQ-021 res_data SHALL retain its last captured value after leaving HOLD until the next capture.
REQ-022 num_passes = 2^PASS_WIDTH-1 (15 by default) SHALL sum exactly 15 beats with no counter wrap.
REQ-023 There SHALL be no arithmetic in this block; summation width and overflow behaviour belong to the accumulator unit.

Reset
REQ-024 While reset=0, the state SHALL be IDLE and the remaining counter SHALL be 0.
REQ-025 While reset=0, res_data SHALL be 0 and res_valid, in_ready, acc_enable, busy and err SHALL all be 0.
REQ-026 acc_clear SHALL be 0 during reset; the accumulator has its own reset.
REQ-027 Reset asserted mid-operation SHALL discard the operation immediately (asynchronous) and not produce res_valid.
REQ-028 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 The state enum and the DATA_WIDTH/PASS_WIDTH default constants SHALL live in a shared package, matrix_accumulate_pkg, reused by the accumulator.
REQ-030 A top-level wrapper, matrix_accumulate_top, SHALL instantiate this sequencer with one matrix_accumulate_unit.
REQ-031 The sequencer itself SHALL contain no sub-module: it is one FSM, one counter and one capture register.

Verification
REQ-032 Reset mid-ACCUM: start with num_passes=3, handshake one beat, assert reset -> all outputs 0 immediately; after release, state IDLE and busy=0.
REQ-033 Basic sum: start with num_passes=3, feed 0x01, 0x02, 0x03 back-to-back with res_ready=0 -> busy rises, acc_clear pulses once, acc_enable is high for 3 cycles, res_valid holds with res_data=0x06 until res_ready.
REQ-034 Gaps: num_passes=2 with in_valid low for 2 cycles between beats 0x10 and 0x20 -> no extra counting, res_data=0x30.
REQ-035 Abort: abort on the same cycle as the 2nd of 4 handshakes -> acc_clear pulses, back in IDLE, res_valid never asserts, res_data unchanged.
REQ-036 Reject and ignore: start with num_passes=0 -> err pulses for exactly 1 cycle and busy stays 0; start during ACCUM -> ignored, the count is unaffected.
REQ-037 Max count: num_passes=15, each beat 0x01 -> res_data=0x0F after exactly 15 handshakes.

Source files
------------

// File: rtl/matrix_accumulate_pkg.sv
// Shared types and default widths for the matrix accumulate sequencer and its
// accumulator unit.
package matrix_accumulate_pkg;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int PASS_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;
endpackage

// File: rtl/matrix_accumulate_sequencer_if.sv
// Command, partial-result, accumulator-control and result signals of the
// sequencer, bundled with views for the sequencer, its driver and the accumulator.
interface matrix_accumulate_sequencer_if
    import matrix_accumulate_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PASS_WIDTH = PASS_WIDTH_DEF
);
    logic                  start;
    logic [PASS_WIDTH-1:0] num_passes;
    logic                  abort;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] acc_out;
    logic                  acc_clear;
    logic                  acc_enable;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_valid;
    logic                  res_ready;
    logic                  busy;
    logic                  err;

    modport slave (
        input  start, num_passes, abort, in_valid, acc_out, res_ready,
        output in_ready, acc_clear, acc_enable, res_data, res_valid, busy, err
    );

    modport master (
        output start, num_passes, abort, in_valid, acc_out, res_ready,
        input  in_ready, acc_clear, acc_enable, res_data, res_valid, busy, err
    );

    modport acc (
        input  acc_clear, acc_enable,
        output acc_out
    );
endinterface

// File: rtl/matrix_accumulate_top.sv
// Sequencer paired with its accumulator; the partial-result data feeds the
// accumulator directly, the sequencer only steers it.
module matrix_accumulate_top
    import matrix_accumulate_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PASS_WIDTH = PASS_WIDTH_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    matrix_accumulate_sequencer_if bus
);
    matrix_accumulate_sequencer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PASS_WIDTH (PASS_WIDTH)
    ) u_seq (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    matrix_accumulate_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_acc (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_data  (i_data),
        .acc     (bus.acc)
    );
endmodule

// File: rtl/matrix_accumulate_unit.sv
// Accumulator: clear has priority over enable; out already includes the beat
// being enabled so the sequencer can capture the full sum on the last handshake.
module matrix_accumulate_unit
    import matrix_accumulate_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    matrix_accumulate_sequencer_if.acc acc
);
    logic [DATA_WIDTH-1:0] r_acc;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)            r_acc <= '0;
        else if (acc.acc_clear)  r_acc <= '0;
        else if (acc.acc_enable) r_acc <= r_acc + i_data;
    end

    assign acc.acc_out = r_acc + (acc.acc_enable ? i_data : '0);
endmodule

// File: rtl/matrix_accumulate_sequencer.sv
// Pass sequencer: clears the accumulator, counts num_passes handshakes, captures
// the final sum and holds it until the consumer takes it.
module matrix_accumulate_sequencer
    import matrix_accumulate_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PASS_WIDTH = PASS_WIDTH_DEF
) (
    input  logic i_clock,
    input  logic i_reset,
    matrix_accumulate_sequencer_if.slave bus
);
    seq_state_e            r_state;
    seq_state_e            w_next;
    logic [PASS_WIDTH-1:0] r_remaining;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic                  r_err;
    logic                  w_in_ready;
    logic                  w_abort;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_reject;

    always_comb begin
        w_in_ready = (r_state == ACCUM);
        w_abort    = ((r_state == CLEAR) || (r_state == ACCUM)) && bus.abort;
        w_hs       = w_in_ready && bus.in_valid;
        // An aborted beat is neither counted nor captured.
        w_last     = w_hs && !w_abort && (r_remaining == PASS_WIDTH'(1));
        w_accept   = (r_state == IDLE) && bus.start && (bus.num_passes != '0);
        w_reject   = (r_state == IDLE) && bus.start && (bus.num_passes == '0);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CLEAR;
            CLEAR:   w_next = w_abort ? IDLE : ACCUM;
            ACCUM:   if (w_abort) w_next = IDLE;
                     else if (w_last) w_next = HOLD;
            HOLD:    if (bus.res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_res_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_reject;
            if (w_accept)     r_remaining <= bus.num_passes;
            else if (w_abort) r_remaining <= '0;
            else if (w_hs)    r_remaining <= r_remaining - PASS_WIDTH'(1);
            if (w_last) r_res_data <= bus.acc_out;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.acc_enable = bus.in_valid && w_in_ready;
    assign bus.acc_clear  = (r_state == CLEAR) || w_abort;
    assign bus.res_valid  = (r_state == HOLD);
    assign bus.res_data   = r_res_data;
    assign bus.busy       = (r_state != IDLE);
    assign bus.err        = r_err;
endmodule

// File: tb/tb_matrix_accumulate_sequencer.sv
// Bench for the sequencer: table of operations plus hand-written reject, abort
// and reset-mid-operation sequences, with a result scoreboard.
module tb_matrix_accumulate_sequencer;
    import matrix_accumulate_pkg::*;

    typedef struct {
        int          np;
        logic [63:0] base;
        logic [63:0] step;
        int          gap;
        int          poke;
        int          hold;
        logic [63:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic [63:0] acc_reg = '0;
    logic [63:0] exp_q[$];
    logic        prev_v = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          en_cnt = 0;
    int          clr_cnt = 0;
    vec_t        tbl[5];

    matrix_accumulate_sequencer_if #(.DATA_WIDTH(64), .PASS_WIDTH(4)) bus ();

    matrix_accumulate_sequencer #(.DATA_WIDTH(64), .PASS_WIDTH(4)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference accumulator driven by the sequencer's control outputs.
    always @(posedge clk) begin
        if (bus.acc_clear)       acc_reg <= '0;
        else if (bus.acc_enable) acc_reg <= acc_reg + in_data;
    end
    assign bus.acc_out = acc_reg + (bus.acc_enable ? in_data : 64'd0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop one expected sum on each rising edge of res_valid.
    always @(negedge clk) begin
        if (bus.acc_enable) en_cnt++;
        if (bus.acc_clear)  clr_cnt++;
        if (bus.res_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got result %h expected none", bus.res_data);
            end else begin
                chk("sb_res_data", bus.res_data, exp_q.pop_front());
            end
        end
        prev_v = bus.res_valid;
    end

    task automatic run_op(input vec_t v);
        exp_q.push_back(v.exp);
        en_cnt  = 0;
        clr_cnt = 0;
        bus.start      = 1'b1;
        bus.num_passes = 4'(v.np);
        tick();
        bus.start = 1'b0;
        chk("clear_busy", bus.busy, 1);
        chk("clear_acc_clear", bus.acc_clear, 1);
        chk("clear_in_ready", bus.in_ready, 0);
        tick();
        for (int i = 0; i < v.np; i++) begin
            chk("accum_in_ready", bus.in_ready, 1);
            bus.in_valid = 1'b1;
            in_data      = v.base + 64'(i) * v.step;
            if (i == v.poke) begin
                bus.start      = 1'b1;
                bus.num_passes = 4'(v.np + 2);
            end
            #1;
            chk("beat_acc_enable", bus.acc_enable, 1);
            chk("beat_no_err", bus.err, 0);
            tick();
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
            if (i < v.np - 1) begin
                for (int g = 0; g < v.gap; g++) begin
                    #1;
                    chk("gap_acc_enable", bus.acc_enable, 0);
                    chk("gap_res_valid", bus.res_valid, 0);
                    tick();
                end
            end
        end
        chk("hold_res_valid", bus.res_valid, 1);
        chk("hold_in_ready", bus.in_ready, 0);
        chk("hold_res_data", bus.res_data, v.exp);
        bus.abort = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk("hold_stays_valid", bus.res_valid, 1);
            chk("hold_stays_data", bus.res_data, v.exp);
        end
        bus.abort     = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("done_res_valid", bus.res_valid, 0);
        chk("done_busy", bus.busy, 0);
        chk("done_res_data_kept", bus.res_data, v.exp);
        chk("enable_cycles", 64'(en_cnt), 64'(v.np));
        chk("clear_pulses", 64'(clr_cnt), 1);
    endtask

    initial begin
        //           np  base                   step                  gap poke hold exp
        tbl[0] = '{3,  64'h1,                64'h1,                0, -1,  2, 64'h6};
        tbl[1] = '{2,  64'h10,               64'h10,               2, -1,  0, 64'h30};
        tbl[2] = '{4,  64'h100,              64'h1,                1,  1,  1, 64'h406};
        tbl[3] = '{15, 64'h1,                64'h0,                0, -1,  0, 64'hF};
        tbl[4] = '{1,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0,             0, -1,  3, 64'hFFFF_FFFF_FFFF_FFFF};

        bus.start = 1'b0; bus.num_passes = '0; bus.abort = 1'b0;
        bus.in_valid = 1'b0; bus.res_ready = 1'b0;

        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_acc_clear", bus.acc_clear, 0);
        chk("rst_err", bus.err, 0);

        // First start goes in on the first edge after release.
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) run_op(tbl[t]);

        // Rejected start.
        bus.start = 1'b1; bus.num_passes = 4'd0;
        tick();
        bus.start = 1'b0;
        chk("reject_err", bus.err, 1);
        chk("reject_busy", bus.busy, 0);
        tick();
        chk("reject_err_once", bus.err, 0);
        chk("reject_busy_after", bus.busy, 0);

        // Abort on the second of four handshakes.
        clr_cnt = 0;
        bus.start = 1'b1; bus.num_passes = 4'd4;
        tick();
        bus.start = 1'b0;
        tick();
        bus.in_valid = 1'b1; in_data = 64'h7;
        tick();
        in_data = 64'h9; bus.abort = 1'b1;
        #1;
        chk("abort_acc_clear", bus.acc_clear, 1);
        tick();
        bus.in_valid = 1'b0; bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_res_valid", bus.res_valid, 0);
        chk("abort_res_data", bus.res_data, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(); tick();
        chk("abort_clear_pulses", 64'(clr_cnt), 2);
        chk("abort_still_idle", bus.busy, 0);
        run_op(tbl[0]);

        // Reset mid-ACCUM.
        bus.start = 1'b1; bus.num_passes = 4'd3;
        tick();
        bus.start = 1'b0;
        tick();
        bus.in_valid = 1'b1; in_data = 64'h5;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_acc_enable", bus.acc_enable, 0);
        chk("midrst_res_valid", bus.res_valid, 0);
        chk("midrst_res_data", bus.res_data, 0);
        chk("midrst_acc_clear", bus.acc_clear, 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("postrst_busy", bus.busy, 0);
        chk("postrst_res_valid", bus.res_valid, 0);
        run_op(tbl[1]);

        chk("sb_drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
